// File: rtl/host_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : host_uart_pkg
// Brief   : Shared types and constants for the host-side UART transmitter.
// Revision: 1.0 - initial release
// ============================================================================
package host_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int MIN_DIV   = 4;
  localparam int DATA_BITS = 8;

endpackage
`default_nettype wire

// File: rtl/host_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module  : host_uart_fifo
// Brief   : Synchronous FIFO with show-ahead read data and an occupancy count.
// Revision: 1.0 - initial release
// ============================================================================
module host_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int                  c_aw   = $clog2(DEPTH);
  localparam logic [c_aw:0]       c_full = (c_aw + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == c_full);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointers wrap naturally; full/empty come only from the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/host_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : host_uart_tx
// Brief   : FIFO-buffered 8-bit UART transmitter, optional parity, 1/2 stops.
// Revision: 1.0 - initial release
// ============================================================================
module host_uart_tx
  import host_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic                          cfg_par_en,
  input  logic                          cfg_par_odd,
  input  logic                          cfg_stop2,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [DIV_W-1:0] c_min_div  = DIV_W'(MIN_DIV);
  localparam logic [2:0]       c_last_bit = 3'(DATA_BITS - 1);

  tx_state_t        r_state, w_state_nx;
  logic [DIV_W-1:0] r_div_cnt, w_div_cnt_nx;
  logic [DIV_W-1:0] r_div, w_div_nx;
  logic [2:0]       r_bit_idx, w_bit_idx_nx;
  logic [7:0]       r_shift, w_shift_nx;
  logic             r_par, w_par_nx;
  logic             r_par_en, w_par_en_nx;
  logic             r_par_odd, w_par_odd_nx;
  logic             r_stop2, w_stop2_nx;
  logic             r_stop_extra, w_stop_extra_nx;
  logic             r_txd, w_txd_nx;

  logic             w_full, w_empty, w_pop, w_bit_end, w_load;
  logic [7:0]       w_head;
  logic [DIV_W-1:0] w_eff_div;

  host_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (in_valid),
    .pop   (w_pop),
    .wdata (in_data),
    .rdata (w_head),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign in_ready  = ~w_full;
  assign busy      = (r_state != IDLE) || !w_empty;
  assign txd       = r_txd;
  assign w_eff_div = (cfg_div < c_min_div) ? c_min_div : cfg_div;
  assign w_bit_end = (r_div_cnt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_div_cnt    <= '0;
      r_div        <= c_min_div;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_par_en     <= 1'b0;
      r_par_odd    <= 1'b0;
      r_stop2      <= 1'b0;
      r_stop_extra <= 1'b0;
      r_txd        <= 1'b1;
    end else begin
      r_state      <= w_state_nx;
      r_div_cnt    <= w_div_cnt_nx;
      r_div        <= w_div_nx;
      r_bit_idx    <= w_bit_idx_nx;
      r_shift      <= w_shift_nx;
      r_par        <= w_par_nx;
      r_par_en     <= w_par_en_nx;
      r_par_odd    <= w_par_odd_nx;
      r_stop2      <= w_stop2_nx;
      r_stop_extra <= w_stop_extra_nx;
      r_txd        <= w_txd_nx;
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_div_cnt_nx    = w_bit_end ? r_div_cnt : r_div_cnt - 1'b1;
    w_div_nx        = r_div;
    w_bit_idx_nx    = r_bit_idx;
    w_shift_nx      = r_shift;
    w_par_nx        = r_par;
    w_par_en_nx     = r_par_en;
    w_par_odd_nx    = r_par_odd;
    w_stop2_nx      = r_stop2;
    w_stop_extra_nx = r_stop_extra;
    w_txd_nx        = r_txd;
    w_load          = 1'b0;

    case (r_state)
      IDLE: begin
        w_txd_nx = 1'b1;
        if (!w_empty) w_load = 1'b1;
      end
      START: begin
        if (w_bit_end) begin
          w_state_nx   = DATA;
          w_txd_nx     = r_shift[0];
          w_par_nx     = r_shift[0];
          w_shift_nx   = r_shift >> 1;
          w_bit_idx_nx = '0;
          w_div_cnt_nx = r_div - 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_div_cnt_nx = r_div - 1'b1;
          if (r_bit_idx == c_last_bit) begin
            if (r_par_en) begin
              w_state_nx = PARITY;
              w_txd_nx   = r_par ^ r_par_odd;
            end else begin
              w_state_nx      = STOP;
              w_txd_nx        = 1'b1;
              w_stop_extra_nx = r_stop2;
            end
          end else begin
            w_bit_idx_nx = r_bit_idx + 1'b1;
            w_txd_nx     = r_shift[0];
            w_par_nx     = r_par ^ r_shift[0];
            w_shift_nx   = r_shift >> 1;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nx      = STOP;
          w_txd_nx        = 1'b1;
          w_stop_extra_nx = r_stop2;
          w_div_cnt_nx    = r_div - 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_stop_extra) begin
            w_stop_extra_nx = 1'b0;
            w_div_cnt_nx    = r_div - 1'b1;
          end else if (!w_empty) begin
            w_load = 1'b1;
          end else begin
            w_state_nx = IDLE;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_txd_nx   = 1'b1;
      end
    endcase

    // Frame start: shadow the config so mid-frame changes wait for the next byte.
    if (w_load) begin
      w_state_nx   = START;
      w_txd_nx     = 1'b0;
      w_shift_nx   = w_head;
      w_div_nx     = w_eff_div;
      w_div_cnt_nx = w_eff_div - 1'b1;
      w_par_en_nx  = cfg_par_en;
      w_par_odd_nx = cfg_par_odd;
      w_stop2_nx   = cfg_stop2;
    end
  end

  assign w_pop = w_load;

endmodule
`default_nettype wire

// File: doc/host_uart_tx.md
# host_uart_tx

Synthesizable UART transmitter that drives the `rxd` pin of `chip_top`, so a host-side harness or companion FPGA can send characters into the SoC's UART receiver rather than holding the line idle. It accepts bytes over a valid/ready port into a small FIFO and serialises them as 8-bit frames, LSB first, with optional parity and 1 or 2 stop bits. Frames go out back-to-back with no extra idle time while the FIFO holds data.

## Interface
- `FIFO_DEPTH`, default 8: byte FIFO entries; power of two, at least 2.
- `DIV_W`, default 16: width of the baud divisor.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `cfg_div` in DIV_W: clock cycles per bit; values below 4 are treated as 4.
- `cfg_par_en` in 1: 1 = append a parity bit after the data.
- `cfg_par_odd` in 1: 1 = odd parity, 0 = even parity.
- `cfg_stop2` in 1: 1 = two stop bits, 0 = one stop bit.
- `in_valid` in 1: byte offered.
- `in_data` in 8: byte to send.
- `in_ready` out 1: FIFO not full.
- `txd` out 1: serial output; idles high. Connects to the SoC `rxd`.
- `busy` out 1: FIFO non-empty or a frame in progress.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of bytes queued, not counting the byte in flight.

## Operation
- **Write.** A byte is accepted when `in_valid && in_ready` at a rising edge. `in_ready = (fifo_count != FIFO_DEPTH)`. A pop in the same cycle does not raise `in_ready` when the FIFO is full.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE.** `txd`=1. If the FIFO is non-empty:
  - pop the head byte into the shift register;
  - latch `cfg_*` into shadow registers (effective divisor = max(cfg_div,4));
  - go to START with `txd`=0.
- **START.** Hold for one bit period, then go to DATA.
- **DATA.**
  - Send `shift[0]`, then shift right; 8 bits, LSB first.
  - A 3-bit counter tracks the bit index.
  - Parity accumulates as XOR of the data bits.
  - After bit 7, go to PARITY if parity is enabled, otherwise STOP.
- **PARITY.** Send XOR(data) for even parity, ~XOR(data) for odd parity. Then go to STOP.
- **STOP.**
  - `txd`=1 for 1 or 2 bit periods, per the latched `cfg_stop2`.
  - At the end of the period: if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Config changes.** Changes to `cfg_*` mid-frame take effect at the next frame start only.
- **Bit timing.** A down-counter loads divisor-1 at each bit start. The bit ends when the counter reads 0.
- **Outputs.**
  - `txd` is a registered FSM output and never glitches.
  - `busy` = (state != IDLE) || (fifo_count != 0).

## Timing
- Reset values: `txd`=1, `in_ready`=1, `busy`=0, `fifo_count`=0, state=IDLE. The FIFO is emptied and the counters cleared.
- Reset mid-frame aborts the frame immediately; `txd` goes high asynchronously. A partially sent byte is not retried.
- Latency: a byte written at edge N into an empty FIFO with the FSM in IDLE sees `txd` fall after edge N+1.
- Frame length in cycles: D·(10 + par_en + stop2), where D is the effective divisor.
- Empty: `txd` stays 1 and `busy`=0.
- Full: `in_ready`=0 until the FSM pops.
- Simultaneous push and pop with the FIFO non-full and non-empty: `fifo_count` is unchanged.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty detection comes from `fifo_count`.

## Structure
- **Package `host_uart_pkg`:**
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - constant `MIN_DIV` = 4;
  - constant `DATA_BITS` = 8.
- **Sub-module `host_uart_fifo`:** synchronous FIFO, parameterised on width and depth.
  - Ports: `push`, `pop`, `wdata`, `rdata`, `count`, `full`, `empty`.
  - `rdata` is valid combinationally whenever the FIFO is not empty.
- **Top `host_uart_tx`:** FSM, divisor counter, bit counter, shift register, parity, shadow config.
- Expected size: about 200 lines of RTL in total.

## Test plan
- **Basic frame.** `cfg_div`=4, no parity, 1 stop, push 0x55.
  - `txd` sequence: 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles.
  - 40 cycles total.
  - `busy` drops the cycle after the stop bit ends.
- **Parity and two stops.** `cfg_div`=8, even parity, `cfg_stop2`=1, push 0x07.
  - Parity bit = 1.
  - Frame is 12 bits = 96 cycles.
  - Repeat with odd parity: parity bit = 0.
- **FIFO full and back-to-back.** `cfg_div`=4, 8 stop... push 10 bytes 0x00..0x09 with `in_valid` held high.
  - The first byte leaves the FIFO after one cycle, so 8 more are accepted (9 total) before `in_ready` goes low.
  - The remaining byte is accepted only after the next pop.
  - All bytes are transmitted in order with no idle cycle between a stop bit and the next start bit.
- **Divisor clamp.** `cfg_div`=1, push 0xFF.
  - Every bit lasts 4 cycles.
  - Frame = 40 cycles.
- **Config latching.** Change `cfg_div` from 4 to 16 mid-frame.
  - The current frame keeps 4 cycles/bit.
  - The next frame uses 16.
- **Reset mid-frame.** Assert `rstn`=0 during bit 3 of 0xA5 with 3 bytes queued.
  - `txd`=1 immediately; `fifo_count`=0, `busy`=0, `in_ready`=1.
  - After release, nothing is transmitted until new data is pushed.
